ascon_perm_ctrl: RTL



---
 rtl/ascon_pkg.sv | 27 ++
 rtl/ascon_perm_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ascon_pkg.sv
// Shared constants and types for the Ascon permutation controller.
// Holds the state/counter widths, legal round limits, the WAIT_DONE
// timeout and the controller FSM encoding.
package ascon_pkg;

  localparam int unsigned STATE_W    = 320;
  localparam int unsigned CTR_W      = 5;
  localparam int unsigned MAX_ROUNDS = 12;
  localparam int unsigned ROUNDS_A   = 12;
  localparam int unsigned ROUNDS_B   = 6;
  localparam int unsigned TIMEOUT    = 4;
  localparam int unsigned TMO_W      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    WAIT_DONE,
    RESP_ERR
  } ctrl_state_t;

  // A round count is runnable when it lies in 1..MAX_ROUNDS.
  function automatic logic rounds_legal(input logic [CTR_W-1:0] r);
    return (r != '0) && (r <= CTR_W'(MAX_ROUNDS));
  endfunction

endpackage

// File: rtl/ascon_perm_ctrl.sv
// Ascon permutation sequencer.
// Accepts {state, rounds} on a valid/ready request channel, drives the
// core load/round interface (perm_start, perm_ctr, perm_rounds, perm_s),
// waits for perm_done and returns {out_state, out_err} on a valid/ready
// response channel through a single-entry output register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_state/in_rounds    request channel
//   out_valid/out_ready/out_state/out_err   response channel
//   busy                           controller not idle
//   perm_start/perm_ctr/perm_rounds/perm_s  core control and load state
//   perm_out/perm_done             core result and done
module ascon_perm_ctrl
  import ascon_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [CTR_W-1:0]   in_rounds,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               out_err,
  output logic               busy,
  output logic               perm_start,
  output logic [CTR_W-1:0]   perm_ctr,
  output logic [CTR_W-1:0]   perm_rounds,
  output logic [STATE_W-1:0] perm_s,
  input  logic [STATE_W-1:0] perm_out,
  input  logic               perm_done
);

  ctrl_state_t        state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               perm_start_q, perm_start_d;
  logic [CTR_W-1:0]   perm_ctr_q, perm_ctr_d;
  logic [CTR_W-1:0]   perm_rounds_q, perm_rounds_d;
  logic [STATE_W-1:0] perm_s_q, perm_s_d;
  logic               out_valid_q, out_valid_d;
  logic               out_err_q, out_err_d;
  logic [STATE_W-1:0] out_state_q, out_state_d;
  // Counts idle-core cycles in WAIT_DONE; in RESP_ERR it marks the
  // first cycle so the error response has the same two-cycle pacing.
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic accept;
  logic out_free;

  assign accept   = in_valid && in_ready_q;
  // Output register can take a new result if empty or draining now.
  assign out_free = !out_valid_q || out_ready;

  // Next-state, core control and output register update.
  always_comb begin
    state_d       = state_q;
    perm_start_d  = 1'b0;
    perm_ctr_d    = perm_ctr_q;
    perm_rounds_d = perm_rounds_q;
    perm_s_d      = perm_s_q;
    tmo_d         = tmo_q;
    out_valid_d   = out_valid_q && !out_ready;
    out_err_d     = out_err_q;
    out_state_d   = out_state_q;

    unique case (state_q)
      IDLE: begin
        perm_ctr_d = '0;
        tmo_d      = '0;
        if (accept) begin
          perm_s_d      = in_state;
          perm_rounds_d = in_rounds;
          if (rounds_legal(in_rounds)) begin
            state_d      = LOAD;
            perm_start_d = 1'b1;
          end else begin
            state_d = RESP_ERR;
          end
        end
      end

      LOAD: begin
        state_d      = ROUND;
        perm_start_d = 1'b1;
        perm_ctr_d   = CTR_W'(1);
      end

      ROUND: begin
        if (perm_ctr_q == perm_rounds_q) begin
          // Hold ctr at R with start low so the core keeps its state.
          state_d = WAIT_DONE;
          tmo_d   = '0;
        end else begin
          perm_start_d = 1'b1;
          perm_ctr_d   = perm_ctr_q + CTR_W'(1);
        end
      end

      WAIT_DONE: begin
        if (perm_done || (tmo_q == TMO_W'(TIMEOUT))) begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_err_d   = !perm_done;
            out_state_d = perm_out;
            perm_ctr_d  = '0;
            tmo_d       = '0;
            state_d     = IDLE;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      RESP_ERR: begin
        if (tmo_q == '0) begin
          tmo_d = TMO_W'(1);
        end else if (out_free) begin
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_state_d = perm_s_q;
          tmo_d       = '0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        perm_ctr_d = '0;
        tmo_d      = '0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      perm_start_q  <= 1'b0;
      perm_ctr_q    <= '0;
      perm_rounds_q <= '0;
      perm_s_q      <= '0;
      tmo_q         <= '0;
      out_valid_q   <= 1'b0;
      out_err_q     <= 1'b0;
      out_state_q   <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      perm_start_q  <= perm_start_d;
      perm_ctr_q    <= perm_ctr_d;
      perm_rounds_q <= perm_rounds_d;
      perm_s_q      <= perm_s_d;
      tmo_q         <= tmo_d;
      out_valid_q   <= out_valid_d;
      out_err_q     <= out_err_d;
      out_state_q   <= out_state_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign perm_start  = perm_start_q;
  assign perm_ctr    = perm_ctr_q;
  assign perm_rounds = perm_rounds_q;
  assign perm_s      = perm_s_q;
  assign out_valid   = out_valid_q;
  assign out_err     = out_err_q;
  assign out_state   = out_state_q;

endmodule
